axis_addr_arbiter: RTL and testbench

- Shares one AXI write address channel between N_PORTS independent address generators.
- Each requester presents an address/length request; the block arbitrates round-robin, registers the winner and drives the AXI address handshake.
- Each grant also pushes the winner's ID and burst length into an order FIFO, so the downstream write-data mux replays data beats in the same order as the addresses.

---
 rtl/axis_addr_arbiter_pkg.sv | 14 +
 rtl/axis_arb_fifo.sv | 65 ++++++
 rtl/axis_addr_arbiter.sv | 139 +++++++++++++
 tb/tb_axis_addr_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_addr_arbiter_pkg.sv
// Shared definitions for the AXI address arbiter: one-hot state indices
// and the state encoding built from them.
package axis_arb_defs;

  // Bit positions inside the one-hot state vector.
  localparam int IDLE  = 0;
  localparam int ISSUE = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b01,
    S_ISSUE = 2'b10
  } state_t;

endpackage

// File: rtl/axis_arb_fifo.sv
// Order FIFO for the address arbiter: records {port id, burst length} per
// grant so the write-data side can replay beats in address order.
// Full and empty are registered flags computed from the next count.
module axis_arb_fifo #(
  parameter int WIDTH  = 9,
  parameter int AWIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH:0]   count;
  logic [AWIDTH:0]   count_d;
  logic              do_push;
  logic              do_pop;

  // Guard both ports so overflow and underflow can never happen.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count;
    case ({do_push, do_pop})
      2'b10:   count_d = count + 1'b1;
      2'b01:   count_d = count - 1'b1;
      default: count_d = count;
    endcase
  end

  // Pointers, count and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_d;
      full  <= (count_d == (AWIDTH+1)'(DEPTH));
      empty <= (count_d == '0);
    end
  end

  // Storage write; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/axis_addr_arbiter.sv
// Round-robin arbiter sharing one AXI write address channel between
// N_PORTS requesters. Each grant is also logged in an order FIFO.
// Define AXIS_ARB_FIXED_PRIORITY_EN for fixed priority (lowest index wins,
// no rotating pointer).
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high at the clock edge; valid never depends on ready on the same side.
module axis_addr_arbiter
  import axis_arb_defs::*;
#(
  parameter int N_PORTS        = 2,
  parameter int ID_WIDTH       = 1,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int FIFO_AWIDTH    = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_PORTS*AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [N_PORTS*AXI_LEN_WIDTH-1:0]  req_len,
  input  logic [N_PORTS-1:0]                req_valid,
  output logic [N_PORTS-1:0]                req_ready,
  input  logic                              axi_aready,
  output logic [AXI_ADDR_WIDTH-1:0]         axi_aaddr,
  output logic [AXI_LEN_WIDTH-1:0]          axi_alen,
  output logic                              axi_avalid,
  output logic [ID_WIDTH-1:0]               ord_id,
  output logic [AXI_LEN_WIDTH-1:0]          ord_len,
  output logic                              ord_valid,
  input  logic                              ord_ready,
  output state_t                            dbg_state
);

  state_t                    state_q;
  state_t                    state_d;
  logic                      grant;
  logic [ID_WIDTH:0]         pick;
  logic                      found;
  logic [ID_WIDTH-1:0]       winner;
  logic [ID_WIDTH-1:0]       rr_ptr;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [AXI_ADDR_WIDTH-1:0] addr_arr [N_PORTS];
  logic [AXI_LEN_WIDTH-1:0]  len_arr  [N_PORTS];

  // Returns {found, index} of the first valid port at or after start,
  // scanning cyclically. The reverse loop lets the nearest port win.
  function automatic logic [ID_WIDTH:0] pick_winner(
    input logic [N_PORTS-1:0]  valid,
    input logic [ID_WIDTH-1:0] start
  );
    logic [ID_WIDTH:0] r;
    int                idx;
    r = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      idx = (int'(start) + i) % N_PORTS;
      if (valid[idx]) r = {1'b1, ID_WIDTH'(idx)};
    end
    return r;
  endfunction

  // Unpack the flat request buses into per-port arrays.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      addr_arr[i] = req_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
      len_arr[i]  = req_len[i*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
    end
  end

  assign pick   = pick_winner(req_valid, rr_ptr);
  assign found  = pick[ID_WIDTH];
  assign winner = pick[ID_WIDTH-1:0];

`ifdef AXIS_ARB_FIXED_PRIORITY_EN
  assign rr_ptr = '0;
`else
  // Rotating pointer: the port after the last winner gets first look.
  always_ff @(posedge clk) begin
    if (rst)                                   rr_ptr <= '0;
    else if (grant && winner == ID_WIDTH'(N_PORTS - 1)) rr_ptr <= '0;
    else if (grant)                            rr_ptr <= winner + 1'b1;
  end
`endif

  // Next-state and combinational grant; ready is offered only in IDLE.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    grant     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found && !fifo_full) begin
          grant             = 1'b1;
          req_ready[winner] = 1'b1;
          state_d           = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (axi_aready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Address/length register, loaded only on a grant and held during ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      axi_aaddr <= '0;
      axi_alen  <= '0;
    end else if (grant) begin
      axi_aaddr <= addr_arr[winner];
      axi_alen  <= len_arr[winner];
    end
  end

  assign axi_avalid = state_q[ISSUE];
  assign dbg_state  = state_q;
  assign ord_valid  = ~fifo_empty;

  axis_arb_fifo #(
    .WIDTH  (ID_WIDTH + AXI_LEN_WIDTH),
    .AWIDTH (FIFO_AWIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .din   ({winner, len_arr[winner]}),
    .pop   (ord_ready),
    .dout  ({ord_id, ord_len}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_axis_addr_arbiter.sv
// Self-checking bench for axis_addr_arbiter: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_axis_addr_arbiter;
  import axis_arb_defs::*;

  localparam int N     = 2;
  localparam int IDW   = 1;
  localparam int LW    = 8;
  localparam int AW    = 32;
  localparam int FAW   = 3;
  localparam int DEPTH = 1 << FAW;

  logic              clk;
  logic              rst;
  logic [N*AW-1:0]   req_addr;
  logic [N*LW-1:0]   req_len;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic              axi_aready;
  logic [AW-1:0]     axi_aaddr;
  logic [LW-1:0]     axi_alen;
  logic              axi_avalid;
  logic [IDW-1:0]    ord_id;
  logic [LW-1:0]     ord_len;
  logic              ord_valid;
  logic              ord_ready;
  state_t            dbg_state;

  // Reference model: outstanding address slot, rotation pointer and the
  // expected order-FIFO contents.
  logic [IDW+LW-1:0] exp_q[$];
  bit                m_busy;
  int                m_ptr;
  logic [AW-1:0]     m_addr;
  logic [LW-1:0]     m_len;
  int                n_checks;
  int                n_errors;

  axis_addr_arbiter #(
    .N_PORTS(N), .ID_WIDTH(IDW), .AXI_LEN_WIDTH(LW),
    .AXI_ADDR_WIDTH(AW), .FIFO_AWIDTH(FAW)
  ) dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_len(req_len),
    .req_valid(req_valid), .req_ready(req_ready), .axi_aready(axi_aready),
    .axi_aaddr(axi_aaddr), .axi_alen(axi_alen), .axi_avalid(axi_avalid),
    .ord_id(ord_id), .ord_len(ord_len), .ord_valid(ord_valid),
    .ord_ready(ord_ready), .dbg_state(dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_busy = 1'b0;
    m_ptr  = 0;
    m_addr = '0;
    m_len  = '0;
  endtask

  // Reset for two cycles with all requests idle.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; axi_aready = 1'b0; ord_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_avalid", axi_avalid, 1'b0);
    check("rst_ord_valid", ord_valid, 1'b0);
    check("rst_aaddr", axi_aaddr, '0);
    check("rst_alen", axi_alen, '0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, check outputs against the model, advance it.
  task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                      input logic [N*LW-1:0] l, input logic ar, input logic orr);
    int           w;
    int           idx;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    req_valid = v; req_addr = a; req_len = l; axi_aready = ar; ord_ready = orr;
    #1;
    w = -1;
    if (!m_busy && exp_q.size() < DEPTH) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (v[idx] && w < 0) w = idx;
      end
    end
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    check("axi_avalid", axi_avalid, m_busy);
    check("axi_aaddr", axi_aaddr, m_addr);
    check("axi_alen", axi_alen, m_len);
    check("ord_valid", ord_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("ord_id", ord_id, exp_q[0][IDW+LW-1:LW]);
      check("ord_len", ord_len, exp_q[0][LW-1:0]);
    end
    @(posedge clk);
    if (orr && exp_q.size() != 0) void'(exp_q.pop_front());
    if (w >= 0) begin
      exp_q.push_back({w[IDW-1:0], l[w*LW +: LW]});
      m_busy = 1'b1;
      m_addr = a[w*AW +: AW];
      m_len  = l[w*LW +: LW];
`ifndef AXIS_ARB_FIXED_PRIORITY_EN
      m_ptr = (w + 1) % N;
`endif
    end else if (m_busy && ar) begin
      m_busy = 1'b0;
    end
  endtask

  function automatic logic [N*AW-1:0] rand_addr();
    logic [N*AW-1:0] r;
    for (int i = 0; i < N; i++) r[i*AW +: AW] = $urandom;
    return r;
  endfunction

  function automatic logic [N*LW-1:0] rand_len();
    logic [N*LW-1:0] r;
    for (int i = 0; i < N; i++) r[i*LW +: LW] = LW'($urandom);
    return r;
  endfunction

  task automatic rand_step(input int p_valid, input int p_ready, input int p_pop);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 99) < p_valid);
    step(v, rand_addr(), rand_len(), $urandom_range(0, 99) < p_ready,
         $urandom_range(0, 99) < p_pop);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; req_valid = '0; req_addr = '0; req_len = '0;
    axi_aready = 1'b0; ord_ready = 1'b0;
    model_reset();
    do_reset();

    // Single request from port 0.
    step(2'b01, {32'h0, 32'h1000}, {8'h0, 8'd255}, 1'b1, 1'b0);
    step(2'b00, {32'h0, 32'h1000}, {8'h0, 8'd255}, 1'b1, 1'b0);
    step(2'b00, rand_addr(), rand_len(), 1'b1, 1'b0);
    #1;
    check("single_ord_id", ord_id, 1'b0);
    check("single_ord_len", ord_len, 8'd255);
    check("single_aaddr", axi_aaddr, 32'h1000);

    // Contention: both ports always valid, address always accepted.
    do_reset();
    repeat (16) step(2'b11, rand_addr(), rand_len(), 1'b1, 1'b1);

    // Backpressure: slave stalls for 5 cycles while both ports request.
    do_reset();
    step(2'b11, rand_addr(), rand_len(), 1'b0, 1'b1);
    repeat (5) step(2'b11, rand_addr(), rand_len(), 1'b0, 1'b1);
    repeat (4) step(2'b11, rand_addr(), rand_len(), 1'b1, 1'b1);

    // FIFO full: no pops, fill 8 entries, then a single pop releases one grant.
    do_reset();
    repeat (24) step(2'b11, rand_addr(), rand_len(), 1'b1, 1'b0);
    #1;
    check("full_ord_valid", ord_valid, 1'b1);
    step(2'b11, rand_addr(), rand_len(), 1'b1, 1'b1);
    repeat (4) step(2'b11, rand_addr(), rand_len(), 1'b1, 1'b0);

    // Simultaneous push/pop around a half-full FIFO.
    do_reset();
    repeat (8) step(2'b11, rand_addr(), rand_len(), 1'b1, 1'b0);
    repeat (12) step(2'b11, rand_addr(), rand_len(), 1'b1, 1'b1);

    // Reset while an address is held in ISSUE.
    do_reset();
    step(2'b10, rand_addr(), rand_len(), 1'b0, 1'b0);
    step(2'b11, rand_addr(), rand_len(), 1'b0, 1'b0);
    do_reset();
    step(2'b11, rand_addr(), rand_len(), 1'b1, 1'b0);

    // Random traffic with varying pressure.
    repeat (600) rand_step(50, 60, 50);
    repeat (600) rand_step(90, 30, 20);
    repeat (600) rand_step(30, 90, 90);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
